// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StWaitStop
    } slave_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser for one bus line; I2C_SLAVE_FILTER_EN adds a 3-sample majority filter.
module i2c_sync_filter (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    // Reset to 1 so an idle (pulled-up) bus never looks like an edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    logic [2:0] hist_q;
    logic       maj_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 3'b111;
            maj_q  <= 1'b1;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[1]};
            maj_q  <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                      (hist_q[1] & hist_q[2]);
        end
    end

    assign dout = maj_q;
`else
    assign dout = sync_q[1];
`endif

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target oversampling scl/sda in the clk domain.
// Optional input glitch filter enabled by defining I2C_SLAVE_FILTER_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  logic       sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       rw
);

    slave_state_t state;
    logic         scl_s, sda_s;
    logic         scl_q, sda_q;
    logic [7:0]   sr;
    logic [2:0]   bitcnt;
    logic         done;
    logic         sda_oe;

    i2c_sync_filter u_scl_sync (.clk(clk), .rst(rst), .din(scl), .dout(scl_s));
    i2c_sync_filter u_sda_sync (.clk(clk), .rst(rst), .din(sda), .dout(sda_s));

    // Bus is open-drain: only ever pull low.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign tx_load = scl_fall & (((state == StAddrAck) & rw) | ((state == StReadAck) & done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            sr       <= 8'h00;
            bitcnt   <= 3'd0;
            done     <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
        end else begin
            scl_q    <= scl_s;
            sda_q    <= sda_s;
            rx_valid <= 1'b0;
            if (start_det) begin
                state  <= StAddr;
                sda_oe <= 1'b0;
                sr     <= 8'h00;
                bitcnt <= 3'd0;
                done   <= 1'b0;
                busy   <= 1'b1;
            end else if (stop_det) begin
                state  <= StIdle;
                sda_oe <= 1'b0;
                done   <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    StAddr: begin
                        if (scl_rise) begin
                            sr     <= {sr[6:0], sda_s};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                if (sr[6:0] == SLAVE_ADDR) begin
                                    rw   <= sda_s;
                                    done <= 1'b1;
                                end else begin
                                    state <= StWaitStop;
                                end
                            end
                        end else if (scl_fall && done) begin
                            sda_oe <= 1'b1;
                            done   <= 1'b0;
                            state  <= StAddrAck;
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            bitcnt <= 3'd0;
                            if (rw) begin
                                sr     <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= StRead;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= StWrite;
                            end
                        end
                    end
                    StWrite: begin
                        if (scl_rise) begin
                            sr     <= {sr[6:0], sda_s};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                rx_data  <= {sr[6:0], sda_s};
                                rx_valid <= 1'b1;
                                done     <= 1'b1;
                            end
                        end else if (scl_fall && done) begin
                            sda_oe <= 1'b1;
                            done   <= 1'b0;
                            state  <= StWriteAck;
                        end
                    end
                    StWriteAck: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= StWrite;
                        end
                    end
                    StRead: begin
                        if (scl_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                done <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (done) begin
                                sda_oe <= 1'b0;
                                done   <= 1'b0;
                                state  <= StReadAck;
                            end else begin
                                sr     <= {sr[6:0], sr[7]};
                                sda_oe <= ~sr[6];
                            end
                        end
                    end
                    StReadAck: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                done <= 1'b1;
                            end else begin
                                state <= StWaitStop;
                            end
                        end else if (scl_fall && done) begin
                            done   <= 1'b0;
                            bitcnt <= 3'd0;
                            sr     <= tx_data;
                            sda_oe <= ~tx_data[7];
                            state  <= StRead;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged master, a vector table and random transactions.
`timescale 1ns/1ps
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int         Q   = 10;
    localparam logic [6:0] SLV = 7'h78;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       tx_load, rx_valid, busy, rw;
    wire        sda;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(SLV)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .rw(rw)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_q[$];
    int         tx_cnt = 0;
    bit         slave_low = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (tx_load === 1'b1) tx_cnt++;
        if (sda === 1'b0 && !m_oe) slave_low = 1'b1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(Q);
        scl = 1'b1;  tick(Q);
        m_oe = 1'b1; tick(Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(Q);
        scl = 1'b1;  tick(Q);
        m_oe = 1'b0; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        m_oe = ~b; tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        m_oe = 1'b0; tick(Q);
        scl = 1'b1;  tick(Q);
        b = sda;     tick(Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
    endtask

    // Reference model: only the configured address is acknowledged; writes deliver every byte.
    function automatic logic model_ack(input logic [6:0] a);
        return a == SLV;
    endfunction

    function automatic int model_rx(input logic [6:0] a, input logic rd, input int n);
        return (model_ack(a) && !rd) ? n : 0;
    endfunction

    task automatic do_txn(input string tag, input logic [6:0] addr, input logic rd, input int n,
                          input logic [2:0][7:0] d, input logic exp_ack, input int exp_rx);
        logic       ack;
        logic [7:0] v;
        int         rx0, tx0;
        rx0 = rx_q.size();
        tx0 = tx_cnt;
        slave_low = 1'b0;
        tx_data = d[0];
        bus_start();
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        put_byte({addr, rd}, ack);
        check({tag, "_addr_ack"}, 32'(ack), exp_ack ? 32'(I2C_ACK) : 32'(I2C_NACK));
        if (exp_ack && ack == I2C_ACK) begin
            check({tag, "_rw"}, 32'(rw), 32'(rd));
            for (int i = 0; i < n; i++) begin
                if (!rd) begin
                    put_byte(d[i], ack);
                    check({tag, "_data_ack"}, 32'(ack), 32'(I2C_ACK));
                end else begin
                    get_byte(v);
                    check({tag, "_read_byte"}, 32'(v), 32'(d[i]));
                    if (i < n - 1) tx_data = d[i + 1];
                    put_bit((i < n - 1) ? I2C_ACK : I2C_NACK);
                end
            end
            if (rd) check({tag, "_wait_stop"}, 32'(dut.state), 32'(StWaitStop));
        end
        bus_stop();
        tick(8);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_idle"}, 32'(dut.state), 32'(StIdle));
        check({tag, "_rx_count"}, 32'(rx_q.size() - rx0), 32'(exp_rx));
        for (int i = 0; i < exp_rx; i++) begin
            if (rx0 + i < rx_q.size()) check({tag, "_rx_data"}, 32'(rx_q[rx0 + i]), 32'(d[i]));
        end
        check({tag, "_tx_load_count"}, 32'(tx_cnt - tx0),
              (exp_ack && rd) ? 32'(n) : 32'd0);
        if (!exp_ack) check({tag, "_never_driven"}, 32'(slave_low), 32'd0);
    endtask

    typedef struct packed {
        logic [6:0]      addr;
        logic            rd;
        logic [1:0]      n;
        logic [2:0][7:0] d;
        logic            exp_ack;
        logic [1:0]      exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] v;
        logic [6:0] a;
        logic       rd;
        int         n, rx0;

        vecs[0] = '{addr: 7'h78, rd: 1'b0, n: 2'd1, d: 24'h0000A5, exp_ack: 1'b1, exp_rx: 2'd1};
        vecs[1] = '{addr: 7'h78, rd: 1'b1, n: 2'd1, d: 24'h00003C, exp_ack: 1'b1, exp_rx: 2'd0};
        vecs[2] = '{addr: 7'h55, rd: 1'b0, n: 2'd1, d: 24'h0000A5, exp_ack: 1'b0, exp_rx: 2'd0};
        vecs[3] = '{addr: 7'h78, rd: 1'b0, n: 2'd2, d: 24'h002211, exp_ack: 1'b1, exp_rx: 2'd2};
        vecs[4] = '{addr: 7'h78, rd: 1'b1, n: 2'd2, d: 24'h0096C3, exp_ack: 1'b1, exp_rx: 2'd0};

        tick(4);
        rst = 1'b0;
        tick(4);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_tx_load", 32'(tx_load), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rw", 32'(rw), 32'd0);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_state", 32'(dut.state), 32'(StIdle));

        for (int i = 0; i < 5; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, int'(vecs[i].n),
                   vecs[i].d, vecs[i].exp_ack, int'(vecs[i].exp_rx));
        end

        // Reset while the slave is pulling sda low for read bit 4.
        tx_data = 8'h00;
        bus_start();
        put_byte({SLV, 1'b1}, ack);
        check("rst_rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 3; i++) get_bit(b);
        check("rst_rd_driving", 32'(sda), 32'd0);
        rst = 1'b1;
        tick(1);
        check("rst_sda_released", 32'(sda), 32'd1);
        check("rst_state", 32'(dut.state), 32'(StIdle));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        rst = 1'b0;
        bus_stop();
        tick(4);
        do_txn("rst_then_write", SLV, 1'b0, 1, 24'h00005A, 1'b1, 1);

        // Repeated START in the middle of a written byte.
        tx_data = 8'hC3;
        bus_start();
        put_byte({SLV, 1'b0}, ack);
        check("rs_addr_ack", 32'(ack), 32'(I2C_ACK));
        rx0 = rx_q.size();
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        bus_start();
        check("rs_state_addr", 32'(dut.state), 32'(StAddr));
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_no_rx", 32'(rx_q.size() - rx0), 32'd0);
        put_byte({SLV, 1'b1}, ack);
        check("rs_read_ack", 32'(ack), 32'(I2C_ACK));
        get_byte(v);
        check("rs_read_byte", 32'(v), 32'hC3);
        put_bit(I2C_NACK);
        bus_stop();
        tick(8);
        check("rs_busy_end", 32'(busy), 32'd0);
        check("rs_no_rx_end", 32'(rx_q.size() - rx0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            a  = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
            rd = 1'($urandom);
            n  = $urandom_range(1, 3);
            do_txn($sformatf("rnd%0d", i), a, rd, n, 24'($urandom), model_ack(a),
                   model_rx(a, rd, n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target that sits on the `scl`/`sda` bus opposite the team's I2C master and consumes the transactions it produces. It detects START and STOP, matches a 7-bit address and acknowledges it, then either delivers written bytes to local logic or serialises bytes supplied by local logic onto `sda`. It supports multi-byte writes and reads and repeated START. It runs entirely in the system clock domain, oversampling the bus.

## Interface
- `SLAVE_ADDR`, default 7'b1111000: 7-bit address this target answers to.
- `clk` input, 1 bit: system clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `scl` input, 1 bit: bus clock, driven by the master.
- `sda` inout, 1 bit: bus data; the slave only drives 0 or releases to z, never drives 1.
- `tx_data` input, 8 bits: byte to return on a read; it must be valid when `tx_load` pulses.
- `tx_load` output, 1 bit: one-cycle pulse when `tx_data` is captured into the shifter.
- `rx_data` output, 8 bits: last byte written by the master.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `busy` output, 1 bit: high from any detected START until STOP, reset, or returning to IDLE.
- `rw` output, 1 bit: R/W bit of the last matched address (1 = read).

## Operation
- **Input sampling:** `scl` and `sda` pass through a 2-flop synchroniser, then an edge register.
  - `scl_rise` and `scl_fall` are derived from that register.
  - START = `sda` 1→0 while `scl` is high in both the previous and current sample.
  - STOP = `sda` 0→1 under the same condition.
- **Priority:**
  - START and STOP override every state.
  - If an `sda` change coincides with an `scl` edge, it is treated as data, not START/STOP.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- **START (any state):**
  - Release `sda`; clear `bitcnt` and the shifter.
  - Go to ADDR; set `busy` = 1.
- **STOP (any state):** release `sda`; go to IDLE; set `busy` = 0.
- **ADDR:**
  - Shift `sda` in MSB-first on each `scl_rise`.
  - After the 8th rise, if `sr[7:1] == SLAVE_ADDR`:
    - latch `rw = sr[0]`;
    - at the next `scl_fall`, drive `sda` low and go to ADDR_ACK.
  - Otherwise go to WAIT_STOP; `sda` is never driven.
- **ADDR_ACK:** hold `sda` low until the `scl_fall` that ends the ACK clock. At that fall:
  - `rw` = 0: release `sda`, go to WRITE.
  - `rw` = 1: capture `tx_data`, pulse `tx_load`, drive bit 7, go to READ.
- **WRITE:**
  - Shift in 8 bits on `scl_rise`.
  - After the 8th rise, update `rx_data` and pulse `rx_valid`.
  - At the next `scl_fall`, drive ACK low and go to WRITE_ACK.
  - At the following fall, release `sda` and return to WRITE. Unlimited bytes.
- **READ:**
  - On each `scl_fall`, present the next bit.
  - A 0 bit drives low; a 1 bit releases `sda`.
  - After the 8th rise, release `sda` at the next fall and go to READ_ACK.
- **READ_ACK:** sample `sda` on `scl_rise`.
  - 0 (ACK): at the next fall, capture `tx_data`, pulse `tx_load`, drive bit 7, go to READ.
  - 1 (NACK): go to WAIT_STOP.
- **WAIT_STOP:** `sda` released; only START or STOP are acted on.
- **Reset:**
  - All outputs 0, `rx_data` = 0, `sda` released, state IDLE.
  - Asserting `rst` mid-transaction releases `sda` the next cycle.
  - Bus activity is then ignored until a new START.

## Timing
- Pin-to-detect latency is 3 `clk` (2 sync + 1 edge register). With the filter enabled it is 5 `clk`.
- `sda` drive changes 1 `clk` after `scl_fall` is detected. Drive changes only while `scl` is low.
- `rx_valid` asserts on the cycle after the 8th `scl_rise` is detected.
- `tx_load` asserts on the cycle `scl_fall` is detected.
- Minimum `scl` high or low phase is 8 `clk`. The master's 100-`clk` quarter-bit easily satisfies this.
- `bitcnt` is 3 bits plus a done flag. It wraps to 0 on every byte boundary and on START.

## Configuration
- `I2C_SLAVE_FILTER_EN` defined:
  - each synchronised line passes a 3-sample majority filter;
  - a pulse of 1 `clk` or shorter is rejected;
  - latency increases by 2 `clk`.
- Not defined: the edge logic reads the synchroniser output directly.

## Structure
- Package `i2c_pkg`:
  - `slave_state_t` enum (the eight states);
  - constants `I2C_ACK` = 1'b0 and `I2C_NACK` = 1'b1.
- Sub-module `i2c_sync_filter`:
  - contains the 2-flop synchroniser and the macro-gated majority filter;
  - instantiated once each for `scl` and `sda`.

## Test plan
- **Write transaction** (address 0x78, op 0, data 0xA5):
  - ACK driven low in both ACK slots;
  - `rx_data` = 0xA5 with exactly one `rx_valid` pulse;
  - `busy` falls after STOP; master `ack_err` = 0.
- **Read transaction** (address 0x78, op 1, `tx_data` = 0x3C, master NACK):
  - one `tx_load` pulse;
  - bit sequence on `sda` is 0,0,1,1,1,1,0,0;
  - master `dout` = 0x3C; slave ends in WAIT_STOP, then IDLE.
- **Address mismatch** (address 0x55): `sda` never driven low, no `rx_valid`, master `ack_err` = 1.
- **Two-byte write** (0x11 then 0x22):
  - two `rx_valid` pulses, carrying 0x11 then 0x22;
  - three ACKs total.
- **Reset mid-read:** assert `rst` during READ bit 4.
  - `sda` is z the next cycle; state IDLE; all outputs 0.
  - A following write of 0x5A succeeds.
- **Repeated START:** issue a START during WRITE bit 3.
  - Slave returns to ADDR with no `rx_valid`.
  - A new read of address 0x78 is ACKed.
